// File: rtl/warn_pwm_gen.sv
// Warning-lamp driver: turns the 2-bit PIO mode word into off/solid/blink/breathe
// lamp patterns, switching pattern only at PWM period boundaries so the lamp never glitches.
module warn_pwm_gen #(
  parameter int PRESCALE      = 500,
  parameter int PWM_BITS      = 8,
  parameter int BLINK_PERIODS = 125,
  parameter int RAMP_STEP     = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          mode,
  output logic                led_out,
  output logic                period_strobe,
  output logic [PWM_BITS-1:0] duty
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int PH_W  = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam int MAX_I = (1 << PWM_BITS) - 1;

  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PH_W-1:0]     PH_LAST = PH_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  // A step at or above full scale behaves like full scale; clamping keeps the sum inside PWM_BITS+1 bits.
  localparam logic [PWM_BITS:0]   STEP    = (RAMP_STEP >= MAX_I) ? (PWM_BITS+1)'(MAX_I)
                                                                 : (PWM_BITS+1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_OFF,
    S_ON,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_RAMP_UP,
    S_RAMP_DOWN
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     presc_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;
  logic                strobe_q;
  logic [PWM_BITS:0]   ramp_sum;
  logic                tick, boundary, in_blink, in_ramp;

  assign tick     = (presc_q == PS_LAST);
  assign boundary = tick && (pwm_cnt_q == CNT_MAX);
  assign in_blink = (state_q == S_BLINK_ON) || (state_q == S_BLINK_OFF);
  assign in_ramp  = (state_q == S_RAMP_UP)  || (state_q == S_RAMP_DOWN);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    duty_d   = duty_q;
    ramp_sum = {1'b0, duty_q} + STEP;
    if (boundary) begin
      case (mode)
        2'd0: begin
          state_d = S_OFF;
          phase_d = '0;
          duty_d  = '0;
        end
        2'd1: begin
          state_d = S_ON;
          phase_d = '0;
          duty_d  = CNT_MAX;
        end
        2'd2: begin
          if (!in_blink) begin
            state_d = S_BLINK_ON;
            phase_d = '0;
          end else if (phase_q == PH_LAST) begin
            state_d = (state_q == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
          duty_d = (state_d == S_BLINK_ON) ? CNT_MAX : '0;
        end
        default: begin
          phase_d = '0;
          if (!in_ramp) begin
            state_d = S_RAMP_UP;
            duty_d  = '0;
          end else if (state_q == S_RAMP_UP) begin
            if (ramp_sum >= {1'b0, CNT_MAX}) begin
              state_d = S_RAMP_DOWN;
              duty_d  = CNT_MAX;
            end else begin
              duty_d = ramp_sum[PWM_BITS-1:0];
            end
          end else begin
            if ({1'b0, duty_q} <= STEP) begin
              state_d = S_RAMP_UP;
              duty_d  = '0;
            end else begin
              duty_d = duty_q - STEP[PWM_BITS-1:0];
            end
          end
        end
      endcase
    end
  end

  // Lamp follows the upcoming state so a new pattern shows from the cycle after the boundary.
  always_comb begin
    case (state_d)
      S_OFF, S_BLINK_OFF: led_d = 1'b0;
      S_ON,  S_BLINK_ON:  led_d = 1'b1;
      default:            led_d = (pwm_cnt_q < duty_d);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      phase_q   <= '0;
      duty_q    <= '0;
      state_q   <= S_OFF;
      led_q     <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PS_W'(1);
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      end
      phase_q  <= phase_d;
      duty_q   <= duty_d;
      state_q  <= state_d;
      led_q    <= led_d;
      strobe_q <= boundary;
    end
  end

  assign led_out       = led_q;
  assign period_strobe = strobe_q;
  assign duty          = duty_q;

endmodule

// File: tb/tb_warn_pwm_gen.sv
// Directed bench for warn_pwm_gen: a 32-cycle-period instance and a 4-cycle-period breathe instance.
module tb_warn_pwm_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode = 2'd2;
  logic       led, strobe;
  logic [3:0] duty;
  logic       led_s, strobe_s;
  logic [1:0] duty_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_now  = 0;

  int duty_tab[11] = '{0, 0, 4, 8, 12, 15, 11, 7, 3, 0, 4};
  int cnt_tab[10]  = '{0, 0, 8, 16, 24, 30, 22, 14, 6, 0};
  int cont_tab[7]  = '{0, 0, 4, 8, 15, 0, 4};

  warn_pwm_gen #(.PRESCALE(2), .PWM_BITS(4), .BLINK_PERIODS(2), .RAMP_STEP(4)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode),
    .led_out(led), .period_strobe(strobe), .duty(duty)
  );

  warn_pwm_gen #(.PRESCALE(1), .PWM_BITS(2), .BLINK_PERIODS(2), .RAMP_STEP(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .mode(2'd3),
    .led_out(led_s), .period_strobe(strobe_s), .duty(duty_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc_now, got, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset_n = 1'b0;
    mode    = m;
    repeat (3) @(negedge clk);
    check_eq("rst_led", 32'(led), 0);
    check_eq("rst_duty", 32'(duty), 0);
    check_eq("rst_strobe", 32'(strobe), 0);
    check_eq("rst_duty_s", 32'(duty_s), 0);
    reset_n = 1'b1;
  endtask

  task automatic run_blink(input string tag);
    for (int c = 0; c <= 200; c++) begin
      int  ds;
      logic on;
      cyc_now = c;
      on = (c >= 32) && (((c - 32) / 64) % 2 == 0);
      check_eq("blink_led", 32'(led), 32'(on));
      check_eq("blink_duty", 32'(duty), on ? 15 : 0);
      check_eq("blink_strobe", 32'(strobe), 32'((c >= 32) && (c % 32 == 0)));
      ds = (c >= 4 && (c / 4) % 2 == 0) ? 3 : 0;
      check_eq("small_duty", 32'(duty_s), 32'(ds));
      check_eq("small_strobe", 32'(strobe_s), 32'((c >= 4) && (c % 4 == 0)));
      check_eq("small_led", 32'(led_s), 32'((ds == 3) && ((c - 1) % 4 != 3)));
      if (c == 70)  mode = 2'd2;
      if (c == 100) mode = 2'd0;
      if (c == 110) mode = 2'd2;
      @(negedge clk);
    end
    $display("[tb] %s: checks=%0d errors=%0d", tag, n_checks, n_errors);
  endtask

  initial begin
    // Blink from reset, with mid-period mode glitches that must be ignored.
    do_reset(2'd2);
    run_blink("blink_from_reset");

    // Solid on, then off requested mid-period.
    do_reset(2'd1);
    for (int c = 0; c <= 100; c++) begin
      logic on;
      cyc_now = c;
      on = (c >= 32) && (c <= 63);
      check_eq("on_off_led", 32'(led), 32'(on));
      check_eq("on_off_duty", 32'(duty), on ? 15 : 0);
      check_eq("on_off_strobe", 32'(strobe), 32'((c >= 32) && (c % 32 == 0)));
      if (c == 42) mode = 2'd0;
      @(negedge clk);
    end
    $display("[tb] on_then_off: checks=%0d errors=%0d", n_checks, n_errors);

    // Breathe from S_OFF: duty per period and lamp on-time per period.
    do_reset(2'd3);
    begin
      int acc = 0;
      for (int c = 0; c <= 330; c++) begin
        cyc_now = c;
        if (c >= 33) acc += int'(led);
        if (c >= 64 && c % 32 == 0 && c <= 320) begin
          check_eq("ramp_on_count", 32'(acc), 32'(cnt_tab[c / 32 - 1]));
          acc = 0;
        end
        if (c >= 37 && c % 32 == 5) check_eq("ramp_duty", 32'(duty), 32'(duty_tab[c / 32]));
        @(negedge clk);
      end
    end
    $display("[tb] breathe: checks=%0d errors=%0d", n_checks, n_errors);

    // Async reset mid-ramp at duty 8, then blink again from scratch.
    do_reset(2'd3);
    repeat (98) @(negedge clk);
    cyc_now = 98;
    check_eq("pre_rst_led", 32'(led), 1);
    check_eq("pre_rst_duty", 32'(duty), 8);
    reset_n = 1'b0;
    #1;
    check_eq("async_led", 32'(led), 0);
    check_eq("async_duty", 32'(duty), 0);
    check_eq("async_strobe", 32'(strobe), 0);
    do_reset(2'd2);
    run_blink("blink_after_reset");

    // Breathe -> blink -> breathe restarts the ramp at zero.
    do_reset(2'd3);
    for (int c = 0; c <= 200; c++) begin
      cyc_now = c;
      if (c >= 37 && c % 32 == 5) check_eq("cont_duty", 32'(duty), 32'(cont_tab[c / 32]));
      if (c == 100) mode = 2'd2;
      if (c == 130) mode = 2'd3;
      @(negedge clk);
    end
    $display("[tb] breathe_blink_breathe: checks=%0d errors=%0d", n_checks, n_errors);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc_now);
    $fatal(1, "watchdog expired");
  end

endmodule
